// File: rtl/sb_trans_parser.sv
// Sideband receive parser for AT frames and LT symbol pairs.
// Removes DLE stuffing from de-serialised symbols, buffers AT bytes after STX,
// checks the CRC-16 trailer and reports decoded fields, LT events and coded
// errors. Buffered bytes are readable through a combinational read port.
//
// Ports:
//   sb_clk, rst           sideband clock, asynchronous active-low reset
//   sym_valid/data/error  incoming symbol stream
//   tconnect, tdisconnect link connect / disconnect request levels
//   t_valid ... data_len  good AT frame pulse and its decoded fields
//   lt_valid, lt_sym      LSE/CLSE pair pulse and the LSE symbol
//   trans_error, err_code error pulse and held code
//                         (1 sym, 2 overflow, 3 crc, 4 framing, 5 short)
//   rd_addr, rd_data      random-access buffer read
//   disconnect            block is in the disconnected state
//   crc_det_en            AT frame body is accumulating
module sb_trans_parser #(
  parameter int unsigned MAX_SYMS  = 69,
  parameter bit          CHECK_CRC = 1'b1,
  parameter int unsigned CNT_W     = $clog2(MAX_SYMS + 1)
) (
  input  logic             sb_clk,
  input  logic             rst,
  input  logic             sym_valid,
  input  logic [7:0]       sym_data,
  input  logic             sym_error,
  input  logic             tconnect,
  input  logic             tdisconnect,
  output logic             t_valid,
  output logic             is_command,
  output logic [7:0]       s_address,
  output logic             s_write,
  output logic             s_read,
  output logic [CNT_W-1:0] data_len,
  output logic             lt_valid,
  output logic [7:0]       lt_sym,
  output logic             trans_error,
  output logic [2:0]       err_code,
  input  logic [CNT_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             disconnect,
  output logic             crc_det_en
);

  localparam logic [7:0] SymDle = 8'hFE;
  localparam logic [7:0] SymEtx = 8'h40;

  typedef enum logic [2:0] {
    StDisconnect, StIdle, StDle1, StLt, StAtData, StAtDle, StCheck
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      crc_q, crc_p1_q, crc_p2_q;
  logic             cmd_cand_q;
  logic [7:0]       lt_cand_q;
  logic [7:0]       buf_q [MAX_SYMS];

  logic is_dle, is_stx, is_lse, is_etx, store_req, full, store_en;
  logic [15:0] crc_rx;

  // CRC-16, poly 0x8005, MSB first, no reflection.
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    is_dle = (sym_data == SymDle);
    is_etx = (sym_data == SymEtx);
    is_stx = (sym_data[6:3] == 4'b0100) && (sym_data[1:0] == 2'b00);
    is_lse = (sym_data[7:4] == 4'b0000) && (sym_data[2:0] == 3'b010);
    // Data byte arriving: plain symbol in AT_DATA or second DLE of a stuffed pair.
    store_req = sym_valid && !sym_error && !tdisconnect &&
                (((state_q == StAtData) && !is_dle) || ((state_q == StAtDle) && is_dle));
    full      = (count_q == CNT_W'(MAX_SYMS));
    store_en  = store_req && !full;
    crc_rx    = {buf_q[count_q - CNT_W'(2)], buf_q[count_q - CNT_W'(1)]};
    rd_data   = (rd_addr < CNT_W'(MAX_SYMS)) ? buf_q[rd_addr] : 8'h00;
  end

  // Buffer storage carries no reset.
  always_ff @(posedge sb_clk) begin
    if (store_en) buf_q[count_q] <= sym_data;
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StDisconnect;
      count_q     <= '0;
      crc_q       <= 16'hFFFF;
      crc_p1_q    <= 16'hFFFF;
      crc_p2_q    <= 16'hFFFF;
      cmd_cand_q  <= 1'b0;
      lt_cand_q   <= 8'h00;
      t_valid     <= 1'b0;
      is_command  <= 1'b0;
      s_address   <= 8'h00;
      s_write     <= 1'b0;
      s_read      <= 1'b0;
      data_len    <= '0;
      lt_valid    <= 1'b0;
      lt_sym      <= 8'h00;
      trans_error <= 1'b0;
      err_code    <= 3'd0;
      disconnect  <= 1'b1;
      crc_det_en  <= 1'b0;
    end else begin
      t_valid     <= 1'b0;
      lt_valid    <= 1'b0;
      trans_error <= 1'b0;
      crc_det_en  <= 1'b0;
      if ((state_q != StDisconnect) && tdisconnect) begin
        state_q    <= StDisconnect;
        disconnect <= 1'b1;
      end else if ((state_q != StDisconnect) && sym_valid && sym_error) begin
        state_q     <= StIdle;
        trans_error <= 1'b1;
        err_code    <= 3'd1;
      end else if (store_req) begin
        if (full) begin
          state_q     <= StIdle;
          trans_error <= 1'b1;
          err_code    <= 3'd2;
        end else begin
          // Keep the CRC two bytes behind so the trailer is excluded.
          count_q    <= count_q + CNT_W'(1);
          crc_p2_q   <= crc_p1_q;
          crc_p1_q   <= crc_q;
          crc_q      <= crc16_upd(crc_q, sym_data);
          state_q    <= StAtData;
          crc_det_en <= 1'b1;
        end
      end else begin
        case (state_q)
          StDisconnect: begin
            if (tconnect) begin
              state_q    <= StIdle;
              disconnect <= 1'b0;
            end
          end
          StIdle: begin
            if (sym_valid && is_dle) state_q <= StDle1;
          end
          StDle1: begin
            if (sym_valid) begin
              if (is_stx) begin
                state_q    <= StAtData;
                cmd_cand_q <= sym_data[7];
                count_q    <= '0;
                crc_q      <= crc16_upd(16'hFFFF, sym_data);
                crc_det_en <= 1'b1;
              end else if (is_lse) begin
                state_q   <= StLt;
                lt_cand_q <= sym_data;
              end else if (!is_dle) begin
                state_q     <= StIdle;
                trans_error <= 1'b1;
                err_code    <= 3'd4;
              end
            end
          end
          StLt: begin
            if (sym_valid) begin
              if (sym_data == ~lt_cand_q) begin
                state_q  <= StIdle;
                lt_valid <= 1'b1;
                lt_sym   <= lt_cand_q;
              end else if (is_dle) begin
                state_q <= StDle1;
              end else begin
                state_q     <= StIdle;
                trans_error <= 1'b1;
                err_code    <= 3'd4;
              end
            end
          end
          StAtData: begin
            // Non-DLE symbols are handled by the store path above.
            crc_det_en <= 1'b1;
            if (sym_valid && is_dle) state_q <= StAtDle;
          end
          StAtDle: begin
            if (!sym_valid) begin
              crc_det_en <= 1'b1;
            end else if (is_etx) begin
              state_q <= StCheck;
            end else begin
              state_q     <= StIdle;
              trans_error <= 1'b1;
              err_code    <= 3'd4;
            end
          end
          StCheck: begin
            state_q <= StIdle;
            if (count_q < CNT_W'(4)) begin
              trans_error <= 1'b1;
              err_code    <= 3'd5;
            end else if (CHECK_CRC && (crc_p2_q != crc_rx)) begin
              trans_error <= 1'b1;
              err_code    <= 3'd3;
            end else begin
              t_valid    <= 1'b1;
              is_command <= cmd_cand_q;
              s_address  <= buf_q[0];
              s_write    <= buf_q[1][7];
              s_read     <= ~buf_q[1][7];
              data_len   <= count_q - CNT_W'(4);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/sb_trans_parser.md
Name: sb_trans_parser

Overview:
- Parametrised sideband receive parser: next generation of the AT/LT transactions FSM.
- Consumes de-serialised sideband symbols on sb_clk and removes DLE stuffing (DLE DLE = data 0xFE).
- Buffers up to MAX_SYMS AT bytes, checks CRC-16 internally and reports decoded AT fields, LT events and coded errors to the control unit.
- Buffered bytes are read back through a random-access read port.

Parameters:
MAX_SYMS, 69, max de-stuffed AT bytes after STX, including the 2 CRC bytes; legal range 4..255
CHECK_CRC, 1, 1 = mismatch raises error and suppresses t_valid; 0 = CRC ignored
CNT_W, $clog2(MAX_SYMS+1), width of byte counter and rd_addr

Ports:
sb_clk  in  1  sideband clock
rst  in  1  asynchronous active-low reset
sym_valid  in  1  sym_data valid this cycle; no-valid cycles hold state
sym_data  in  8  received symbol
sym_error  in  1  symbol-level error, qualified by sym_valid
tconnect  in  1  level: link connected
tdisconnect  in  1  level: link disconnect request
t_valid  out  1  1-cycle pulse: good AT frame in buffer
is_command  out  1  STX bit7 of last good frame (1 = command, 0 = response)
s_address  out  8  buffer byte 0
s_write  out  1  buffer byte 1 bit7
s_read  out  1  ~s_write
data_len  out  CNT_W  data-byte count = total bytes - 4
lt_valid  out  1  1-cycle pulse: LSE/CLSE pair received
lt_sym  out  8  received LSE symbol
trans_error  out  1  1-cycle error pulse
err_code  out  3  1 sym_error, 2 overflow, 3 crc, 4 framing, 5 short; held until next error
rd_addr  in  CNT_W  buffer read index
rd_data  out  8  buffer[rd_addr], combinational; 0 when rd_addr >= MAX_SYMS
disconnect  out  1  level: block in DISCONNECT
crc_det_en  out  1  high while an AT frame body is accumulating

Behaviour:
- Reset: state DISCONNECT; disconnect=1; all other outputs 0; byte count 0; CRC register 0xFFFF; buffer contents undefined.
- Symbols are consumed only when sym_valid=1. tdisconnect in any state except DISCONNECT -> DISCONNECT next cycle, frame dropped, no error pulse. Priority: tdisconnect > sym_error > symbol decode.
- DISCONNECT -> IDLE when tconnect=1; disconnect falls on the same edge.
- IDLE: DLE -> DLE1; anything else is ignored.
- DLE1: STX (8'b?0100?00) -> AT_DATA, capture is_command candidate, count=0, CRC=0xFFFF, then CRC over STX. LSE (8'b0000?010) -> LT, latch candidate. DLE -> stay. Other -> IDLE with err 4.
- LT: symbol == ~candidate -> IDLE, lt_valid pulse, lt_sym updated. DLE -> DLE1. Else -> IDLE with err 4.
- AT_DATA: non-DLE -> store at buffer[count], count+1, CRC update. DLE -> AT_DLE.
- AT_DLE: DLE -> store 0xFE as data, back to AT_DATA. ETX (0x40) -> CHECK. Else -> IDLE with err 4.
- Storing when count == MAX_SYMS -> IDLE with err 2.
- CHECK (one cycle, no symbol consumed): count<4 -> err 5. Else CHECK_CRC and CRC over STX..byte[count-3] != {byte[count-2], byte[count-1]} -> err 3. Else t_valid=1 and s_address, s_write, data_len, is_command update on the same edge.
- CRC-16: poly 0x8005, init 0xFFFF, MSB-first, no reflection, no final XOR. The running CRC is snapshotted 2 bytes behind so the CRC bytes are excluded.
- sym_error in any non-DISCONNECT state -> IDLE with err 1 (err pulse also fires in IDLE).
- Error pulse and state change take effect at the edge after the offending symbol.
- Decoded field outputs change only on t_valid; they hold through later errors.
- All outputs are registered except rd_data.
- crc_det_en = 1 in AT_DATA and AT_DLE.
- Latency: ETX sampled at edge N -> t_valid high after edge N+1.

Test Plan:
- Reset, tconnect=1 -> disconnect 1->0. Send FE,05,40? No: send FE,0xA4 (command STX), 0x12, 0x83, 0xAA,0xBB,0xCC, correct CRC, FE,40 -> t_valid 1 cycle; s_address=0x12, s_write=1, data_len=3, is_command=1; rd_addr 2..4 read AA,BB,CC.
- Same frame with data FE,FE in place of 0xAA -> rd_data[2]=0xFE, data_len=3, t_valid.
- Correct frame with 1 CRC bit flipped -> trans_error, err_code=3, no t_valid. Repeat with CHECK_CRC=0 -> t_valid.
- MAX_SYMS=8, 9 body bytes -> err_code=2, state IDLE; next good frame accepted.
- FE,0x02,0xFD -> lt_valid, lt_sym=0x02. FE,0x02,0x11 -> err_code=4.
- sym_error mid-frame -> err 1. tdisconnect mid-frame -> disconnect=1, no error pulse. Reset mid-frame -> all outputs 0, disconnect=1.
